// File: rtl/bus_poller.sv
// Request-driven peripheral bus master: single write, single read, or masked poll
// of one register with a bounded read count and a fixed idle gap between reads.
module bus_poller #(
    parameter int unsigned POLL_LIMIT = 1000,
    parameter int unsigned POLL_GAP   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [1:0] req_addr,
    input  logic [7:0] req_data,
    input  logic [7:0] req_mask,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       cs,
    output logic       we,
    output logic [1:0] addr,
    output logic [7:0] dbw,
    input  logic [7:0] dbr
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_POLL_RD,
        ST_POLL_GAP,
        ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_POLL  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    localparam logic [15:0] LIMIT    = 16'(POLL_LIMIT);
    localparam logic [7:0]  GAP_LAST = 8'(POLL_GAP - 1);

    state_e      state_q, state_d;
    logic        cs_q, cs_d;
    logic        we_q, we_d;
    logic [1:0]  addr_q, addr_d;
    logic [7:0]  dbw_q, dbw_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  mask_q, mask_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  gap_q, gap_d;

    logic        accept;
    logic        match;
    logic [15:0] cnt_inc;

    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign match     = ((dbr ^ data_q) & mask_q) == 8'h00;
    assign cnt_inc   = cnt_q + 16'd1;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        dbw_d      = '0;
        data_d     = data_q;
        mask_d     = mask_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    data_d = req_data;
                    mask_d = req_mask;
                    case (op_e'(req_op))
                        OP_WRITE: begin
                            state_d = ST_WRITE;
                            addr_d  = req_addr;
                            dbw_d   = req_data;
                        end
                        OP_READ: begin
                            state_d = ST_READ;
                            addr_d  = req_addr;
                        end
                        OP_POLL: begin
                            state_d = ST_POLL_RD;
                            addr_d  = req_addr;
                            cnt_d   = '0;
                            gap_d   = '0;
                        end
                        OP_RSVD: begin
                            // no bus cycle, so addr keeps its previous value
                            state_d    = ST_RESP;
                            rsp_data_d = '0;
                            rsp_err_d  = 1'b1;
                        end
                    endcase
                end
            end

            ST_WRITE: begin
                state_d    = ST_RESP;
                rsp_data_d = '0;
                rsp_err_d  = 1'b0;
            end

            ST_READ: begin
                state_d    = ST_RESP;
                rsp_data_d = dbr;
                rsp_err_d  = 1'b0;
            end

            ST_POLL_RD: begin
                cnt_d = cnt_inc;
                // response regs only move on the final read so they hold outside RESP
                if (match) begin
                    state_d    = ST_RESP;
                    rsp_data_d = dbr;
                    rsp_err_d  = 1'b0;
                end else if (cnt_inc == LIMIT) begin
                    state_d    = ST_RESP;
                    rsp_data_d = dbr;
                    rsp_err_d  = 1'b1;
                end else begin
                    state_d = ST_POLL_GAP;
                    gap_d   = '0;
                end
            end

            ST_POLL_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_POLL_RD;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // bus strobes are registered copies of the state being entered
        cs_d = (state_d == ST_WRITE) || (state_d == ST_READ) || (state_d == ST_POLL_RD);
        we_d = (state_d == ST_WRITE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cs_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            dbw_q      <= '0;
            data_q     <= '0;
            mask_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            cnt_q      <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            cs_q       <= cs_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            dbw_q      <= dbw_d;
            data_q     <= data_d;
            mask_q     <= mask_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
        end
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign cs        = cs_q;
    assign we        = we_q;
    assign addr      = addr_q;
    assign dbw       = dbw_q;

endmodule

// File: doc/bus_poller.md
BUS_POLLER -- requirements
Module: bus_poller

Interface
REQ-001 Parameter POLL_LIMIT, default 1000: maximum number of read cycles in one poll operation, legal range 1..65535.
REQ-002 Parameter POLL_GAP, default 1: idle bus cycles between consecutive poll reads, legal range 1..255.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  upstream request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_op  input  2  00 write, 01 read, 10 poll, 11 reserved.
REQ-008 req_addr  input  2  peripheral register address.
REQ-009 req_data  input  8  write data (write) or match value (poll).
REQ-010 req_mask  input  8  bit mask for poll comparison; ignored otherwise.
REQ-011 rsp_valid  output  1  one-cycle response pulse, no backpressure.
REQ-012 rsp_data  output  8  read/poll result; 0 for write and reserved ops.
REQ-013 rsp_err  output  1  qualifies rsp_valid: poll timeout or reserved op.
REQ-014 cs  output  1  peripheral select, registered.
REQ-015 we  output  1  peripheral write enable, registered.
REQ-016 addr  output  2  peripheral address, registered.
REQ-017 dbw  output  8  peripheral write data, registered.
REQ-018 dbr  input  8  peripheral read data, valid combinationally while cs=1 and we=0.

Function
REQ-019 States: IDLE, WRITE, READ, POLL_RD, POLL_GAP, RESP.
REQ-020 req_ready SHALL be 1 only in IDLE with rst low; a request is accepted on a rising edge where req_valid and req_ready are both 1, latching op, addr, data, and mask.
REQ-021 Transitions on acceptance: op 00 to WRITE, 01 to READ, 10 to POLL_RD (poll count cleared), 11 to RESP with rsp_err=1 and no bus cycle.
REQ-022 WRITE: for exactly one cycle cs=1, we=1, addr=latched addr, dbw=latched data; next state RESP.
REQ-023 dbw SHALL be 0 in every cycle other than a WRITE cycle; addr holds its last value while cs=0.
REQ-024 READ: for exactly one cycle cs=1, we=0, addr=latched addr; dbr is captured on the rising edge ending that cycle; next state RESP with rsp_data=captured value.
REQ-025 POLL_RD: one read cycle as in READ; the poll count increments on capture.
REQ-026 Match condition: (dbr & mask) == (data & mask); on match, go to RESP with rsp_data=dbr and rsp_err=0; mask 0x00 matches on the first read.
REQ-027 On no match with count == POLL_LIMIT, go to RESP with rsp_data=last dbr and rsp_err=1; otherwise go to POLL_GAP.
REQ-028 POLL_GAP: cs=0 for exactly POLL_GAP cycles, then return to POLL_RD.
REQ-029 RESP: rsp_valid=1 for one cycle with rsp_data and rsp_err stable; next state IDLE. Outside RESP, rsp_valid=0 and rsp_data and rsp_err hold their values.
REQ-030 Latency, write/read: acceptance edge N; cs high in cycle N+1; rsp_valid high in cycle N+2; req_ready high again in cycle N+3.
REQ-031 Poll with k reads: cs read pulses at cycles N+1+i*(POLL_GAP+1), for i=0..k-1; rsp_valid is high one cycle after the last pulse.
REQ-032 cs and we SHALL never be 1 in two consecutive cycles within a write or read operation.
REQ-033 req_valid while not ready is ignored; upstream holds the request until accepted.

Reset
REQ-034 While rst=1, independent of clk: state=IDLE, cs=0, we=0, addr=0, dbw=0, rsp_valid=0, rsp_data=0, rsp_err=0, poll and gap counters=0, req_ready=0.
REQ-035 When rst asserts mid-operation, the operation is abandoned and no rsp_valid is produced for it; req_ready=1 from the first cycle after release.

Verification
REQ-036 Reset: assert rst mid-cycle -> all outputs 0 immediately; release -> req_ready=1 next cycle, cs=0.
REQ-037 Write op=00, addr=2, data=0x01 -> exactly one cycle with cs=1, we=1, addr=2, dbw=0x01 at N+1; rsp_valid=1 at N+2 with rsp_data=0, rsp_err=0; dbw=0 elsewhere.
REQ-038 Read op=01, addr=1, responder returns 0x03 -> one cycle with cs=1, we=0 at N+1; rsp_valid at N+2 with rsp_data=0x03, rsp_err=0.
REQ-039 Poll op=10, addr=2, mask=0x80, data=0x80, responder sets bit 7 from the 4th read onward (reads 0x01, then 0x81) -> 4 read pulses spaced POLL_GAP+1 cycles apart; rsp_data=0x81, rsp_err=0.
REQ-040 Poll that never matches, POLL_LIMIT=8, responder returns 0x01 -> exactly 8 read pulses; rsp_err=1, rsp_data=0x01; reserved op=11 -> no cs pulse, rsp_valid at N+1 with rsp_err=1.
REQ-041 rst pulsed during POLL_GAP -> cs stays 0, no rsp_valid for the abandoned poll; a following write is accepted and completes per REQ-030.
